// File: rtl/ray_pkg.sv
// Shared types and constants for the primary-ray scheduler.
// Doubles are carried as opaque 64-bit fields; nothing here does floating-point math.
package ray_pkg;

  localparam int DBL_W = 64;
  localparam int VEC_W = 192;

  // Direction vector field positions: {x, y, z}
  localparam int X_HI = 191;
  localparam int X_LO = 128;
  localparam int Y_HI = 127;
  localparam int Y_LO = 64;
  localparam int Z_HI = 63;
  localparam int Z_LO = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ray_scheduler_pixel_counter.sv
// Raster position counter: walks x across a row, then steps y, wrapping after the last pixel.
// last flags the final pixel of the frame.
module pixel_counter #(
  parameter int H_RES = 64,
  parameter int V_RES = 48,
  parameter int X_W   = $clog2(H_RES),
  parameter int Y_W   = $clog2(V_RES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;
  logic           x_end;
  logic           y_end;

  assign x_end = (x_reg == X_W'(H_RES - 1));
  assign y_end = (y_reg == Y_W'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (inc) begin
      if (x_end) begin
        x_reg <= '0;
        // wrapping past the final row returns to the origin for the next frame
        y_reg <= y_end ? '0 : y_reg + Y_W'(1);
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = x_end && y_end;

endmodule

// File: rtl/ray_scheduler.sv
// Frame sequencer for the sphere-intersect unit: fetch a direction, hold it for the
// intersect latency, capture the hit bit and hand a pixel record downstream.
module ray_scheduler
  import ray_pkg::*;
#(
  parameter int H_RES     = 64,
  parameter int V_RES     = 48,
  parameter int ISECT_LAT = 0,
  parameter int X_W       = $clog2(H_RES),
  parameter int Y_W       = $clog2(V_RES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DBL_W-1:0] rad_in,
  input  logic             dir_valid,
  output logic             dir_ready,
  input  logic [VEC_W-1:0] dir_in,
  output logic [VEC_W-1:0] isect_dir,
  output logic [DBL_W-1:0] isect_rad,
  input  logic             isect_hit,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_hit,
  output logic             pix_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (ISECT_LAT > 0) ? $clog2(ISECT_LAT + 1) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_reg;
  logic [VEC_W-1:0] dir_reg;
  logic [DBL_W-1:0] rad_reg;
  logic             hit_reg;

  logic start_fire;
  logic dir_fire;
  logic pix_fire;
  logic eval_tick;
  logic capture;
  logic frame_last;

  always_comb begin
    state_next = state_reg;
    dir_ready  = 1'b0;
    pix_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_fire = 1'b0;
    dir_fire   = 1'b0;
    pix_fire   = 1'b0;
    eval_tick  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_fire = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        dir_ready = 1'b1;
        busy      = 1'b1;
        if (dir_valid) begin
          dir_fire   = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        busy = 1'b1;
        // the hit bit is only trusted once the latency countdown has expired
        if (wait_reg == '0) begin
          capture    = 1'b1;
          state_next = EMIT;
        end else begin
          eval_tick = 1'b1;
        end
      end
      EMIT: begin
        pix_valid = 1'b1;
        busy      = 1'b1;
        if (pix_ready) begin
          pix_fire   = 1'b1;
          state_next = frame_last ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      dir_reg   <= '0;
      rad_reg   <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_fire) begin
        rad_reg <= rad_in;
      end
      if (dir_fire) begin
        dir_reg  <= {dir_in[X_HI:X_LO], dir_in[Y_HI:Y_LO], dir_in[Z_HI:Z_LO]};
        wait_reg <= CNT_W'(ISECT_LAT);
      end else if (eval_tick) begin
        wait_reg <= wait_reg - CNT_W'(1);
      end
      if (capture) begin
        hit_reg <= isect_hit;
      end
    end
  end

  pixel_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_pixel_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fire),
    .inc   (pix_fire),
    .x     (pix_x),
    .y     (pix_y),
    .last  (frame_last)
  );

  assign isect_dir = dir_reg;
  assign isect_rad = rad_reg;
  assign pix_hit   = hit_reg;
  assign pix_last  = frame_last;

endmodule

// File: tb/tb_ray_scheduler.sv
// Bench for ray_scheduler: one instance with a combinational stub (ISECT_LAT=0) and one
// with a toggling stub (ISECT_LAT=3), both checked against a frame-level reference model.
module tb_ray_scheduler;

  localparam int H = 4;
  localparam int V = 2;
  localparam logic [63:0] RAD_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] RAD_TWO  = 64'h4000000000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [2];
  logic         start     [2];
  logic [63:0]  rad_in    [2];
  logic         dir_valid [2];
  logic         dir_ready [2];
  logic [191:0] dir_in    [2];
  logic [191:0] isect_dir [2];
  logic [63:0]  isect_rad [2];
  logic         pix_valid [2];
  logic         pix_ready [2];
  logic [1:0]   pix_x     [2];
  logic [0:0]   pix_y     [2];
  logic         pix_hit   [2];
  logic         pix_last  [2];
  logic         busy      [2];
  logic         done      [2];
  logic         hit0;
  logic         hit1;

  logic tog = 1'b0;
  int   cyc = 0;
  always @(posedge clk) begin
    tog <= ~tog;
    cyc <= cyc + 1;
  end

  assign hit0 = isect_dir[0][0];
  assign hit1 = tog;

  ray_scheduler #(.H_RES(H), .V_RES(V), .ISECT_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .rad_in(rad_in[0]),
    .dir_valid(dir_valid[0]), .dir_ready(dir_ready[0]), .dir_in(dir_in[0]),
    .isect_dir(isect_dir[0]), .isect_rad(isect_rad[0]), .isect_hit(hit0),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .pix_x(pix_x[0]),
    .pix_y(pix_y[0]), .pix_hit(pix_hit[0]), .pix_last(pix_last[0]),
    .busy(busy[0]), .done(done[0])
  );

  ray_scheduler #(.H_RES(H), .V_RES(V), .ISECT_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .rad_in(rad_in[1]),
    .dir_valid(dir_valid[1]), .dir_ready(dir_ready[1]), .dir_in(dir_in[1]),
    .isect_dir(isect_dir[1]), .isect_rad(isect_rad[1]), .isect_hit(hit1),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .pix_x(pix_x[1]),
    .pix_y(pix_y[1]), .pix_hit(pix_hit[1]), .pix_last(pix_last[1]),
    .busy(busy[1]), .done(done[1])
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  logic [191:0] last_dir [2];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] want);
    ntot++;
    assert (obs === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_dir_ready"}, dir_ready[d], 0);
    chk({tag, "_isect_dir"}, isect_dir[d], 0);
    chk({tag, "_isect_rad"}, isect_rad[d], 0);
    chk({tag, "_pix_valid"}, pix_valid[d], 0);
    chk({tag, "_pix_x"},     pix_x[d], 0);
    chk({tag, "_pix_y"},     pix_y[d], 0);
    chk({tag, "_pix_hit"},   pix_hit[d], 0);
    chk({tag, "_pix_last"},  pix_last[d], 0);
    chk({tag, "_busy"},      busy[d], 0);
    chk({tag, "_done"},      done[d], 0);
  endtask

  // One pixel: entered and left on a negedge with the DUT in FETCH.
  task automatic pixel(input int d, input int k, input logic [191:0] dv, input int dg,
                       input int pg, input logic [63:0] want_rad, input bit poke);
    int   lat   = (d == 0) ? 0 : 3;
    int   n     = 0;
    logic hrec [16];
    logic want_hit;
    chk("fetch_ready", dir_ready[d], 1);
    chk("fetch_pix_valid", pix_valid[d], 0);
    for (int i = 0; i < dg; i++) begin
      if (poke && i == 0) begin
        start[d]  = 1'b1;
        rad_in[d] = RAD_TWO;
      end
      @(negedge clk);
      start[d] = 1'b0;
      chk("stall_ready", dir_ready[d], 1);
      chk("stall_pix_valid", pix_valid[d], 0);
      chk("stall_dir", isect_dir[d], last_dir[d]);
    end
    dir_valid[d] = 1'b1;
    dir_in[d]    = dv;
    @(negedge clk);
    dir_valid[d] = 1'b0;
    dir_in[d]    = rnd192();
    last_dir[d]  = dv;
    while (pix_valid[d] !== 1'b1 && n < 16) begin
      chk("eval_dir", isect_dir[d], dv);
      chk("eval_ready", dir_ready[d], 0);
      hrec[n] = (d == 0) ? hit0 : hit1;
      n++;
      @(negedge clk);
    end
    chk("eval_cycles", n, lat + 1);
    if (d == 0) want_hit = dv[0];
    else        want_hit = (n > lat) ? hrec[lat] : 1'bx;
    for (int j = 0; j <= pg; j++) begin
      chk("emit_valid", pix_valid[d], 1);
      chk("emit_ready", dir_ready[d], 0);
      chk("emit_x", pix_x[d], k % H);
      chk("emit_y", pix_y[d], k / H);
      chk("emit_last", pix_last[d], (k == H * V - 1));
      chk("emit_hit", pix_hit[d], want_hit);
      chk("emit_rad", isect_rad[d], want_rad);
      chk("emit_dir", isect_dir[d], dv);
      if (j == pg) pix_ready[d] = 1'b1;
      @(negedge clk);
      pix_ready[d] = 1'b0;
    end
    $display("pixel inst=%0d (%0d,%0d) hit=%0b last=%0b eval=%0d", d, k % H, k / H,
             pix_hit[d], (k == H * V - 1), n);
  endtask

  // mode 0: no stalls; mode 1: spec vector first, random stalls; mode 2: directed stalls + start poke
  task automatic frame(input int d, input logic [63:0] rad, input logic [63:0] want_rad,
                       input int mode);
    int lat = (d == 0) ? 0 : 3;
    int c0;
    int want_cyc = 0;
    logic [191:0] dv;
    int dg;
    int pg;
    bit poke;
    start[d]  = 1'b1;
    rad_in[d] = rad;
    @(negedge clk);
    start[d]  = 1'b0;
    rad_in[d] = {$urandom, $urandom};
    c0 = cyc;
    chk("start_busy", busy[d], 1);
    chk("start_rad", isect_rad[d], want_rad);
    for (int k = 0; k < H * V; k++) begin
      dv   = rnd192();
      dg   = 0;
      pg   = 0;
      poke = 1'b0;
      if (mode == 0) dv[191:128] = 64'(k);
      if (mode == 1) begin
        dg = int'($urandom_range(0, 2));
        pg = int'($urandom_range(0, 2));
        if (k == 0)
          dv = {$realtobits(-0.0696257353), $realtobits(0.57209301), $realtobits(-1.0)};
      end
      if (mode == 2) begin
        if (k == 1) begin dg = 1; poke = 1'b1; end
        if (k == 2) begin dg = 4; pg = 5; end
      end
      want_cyc += 3 + lat + dg + pg;
      pixel(d, k, dv, dg, pg, want_rad, poke);
    end
    chk("done_pulse", done[d], 1);
    chk("done_busy", busy[d], 0);
    chk("done_ready", dir_ready[d], 0);
    chk("done_pix_valid", pix_valid[d], 0);
    chk("frame_cycles", cyc - c0 + 1, want_cyc + 1);
    @(negedge clk);
    chk("done_single", done[d], 0);
    chk("idle_busy", busy[d], 0);
    $display("frame inst=%0d mode=%0d cycles=%0d", d, mode, cyc - c0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      start[d]     = 1'b0;
      rad_in[d]    = '0;
      dir_valid[d] = 1'b0;
      dir_in[d]    = '0;
      pix_ready[d] = 1'b0;
      last_dir[d]  = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk_zero(0, "idle0");

    frame(0, $realtobits(0.5), RAD_HALF, 0);
    frame(1, $realtobits(0.5), RAD_HALF, 1);
    frame(0, $realtobits(0.5), RAD_HALF, 2);
    frame(0, $realtobits(2.0), RAD_TWO, 0);

    // Abandon a frame mid-EVAL with a 3-cycle reset
    start[1]  = 1'b1;
    rad_in[1] = $realtobits(0.5);
    @(negedge clk);
    start[1]     = 1'b0;
    dir_valid[1] = 1'b1;
    dir_in[1]    = rnd192();
    @(negedge clk);
    dir_valid[1] = 1'b0;
    chk("pre_reset_busy", busy[1], 1);
    chk("pre_reset_eval", pix_valid[1], 0);
    rst_n[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_done", done[1], 0);
    end
    rst_n[1]    = 1'b1;
    last_dir[1] = '0;
    chk_zero(1, "midreset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_done", done[1], 0);
      chk("post_reset_busy", busy[1], 0);
    end
    frame(1, $realtobits(0.5), RAD_HALF, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ray_scheduler.md
Name: ray_scheduler

Overview:
Sequences the combinational sphere-intersect unit across a full frame of primary rays.
- Per pixel: fetches a 3×64-bit ray direction from an upstream direction source via valid/ready, then drives it and a frame-constant radius into the intersect unit.
- Waits the configured intersect latency, captures the hit bit, and emits a pixel record (x, y, hit) downstream via valid/ready.
- Sits between the camera/direction generator and the framebuffer writer.

Parameters:
- H_RES, 64, pixels per row (≥2).
- V_RES, 48, rows per frame (≥2).
- ISECT_LAT, 0, cycles of pipeline latency in the intersect unit (0 = combinational).
- X_W, $clog2(H_RES), x coordinate width (derived).
- Y_W, $clog2(V_RES), y coordinate width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a frame; honoured only in IDLE.
- rad_in  in  64  sphere radius (IEEE-754 double); sampled on an accepted start.
- dir_valid  in  1  upstream direction available.
- dir_ready  out  1  scheduler accepts a direction.
- dir_in  in  192  direction {x[191:128], y[127:64], z[63:0]}, IEEE-754 doubles.
- isect_dir  out  192  registered direction to the intersect unit.
- isect_rad  out  64  registered radius to the intersect unit.
- isect_hit  in  1  intersect result.
- pix_valid  out  1  pixel record valid.
- pix_ready  in  1  downstream accepts the record.
- pix_x  out  X_W  pixel column.
- pix_y  out  Y_W  pixel row.
- pix_hit  out  1  captured hit bit.
- pix_last  out  1  record is the final pixel of the frame.
- busy  out  1  high in FETCH, EVAL and EMIT.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state IDLE. All outputs and internal counters are 0: dir_ready, isect_dir, isect_rad, pix_*, busy, done, x, y, wait counter.
- Reset mid-frame abandons the frame. No done pulse is produced.
- No floating-point arithmetic is performed; doubles pass through as opaque bits.
- IDLE:
  - start=1: latch rad_in into isect_rad, set x=y=0, go to FETCH.
  - start=0: remain in IDLE.
- FETCH:
  - dir_ready=1.
  - On dir_valid&dir_ready: load isect_dir←dir_in, load wait counter←ISECT_LAT, go to EVAL.
  - dir_ready is asserted only in FETCH.
- EVAL:
  - isect_dir and isect_rad are held stable.
  - If the wait counter is non-zero, decrement it.
  - If the wait counter is 0: capture pix_hit←isect_hit, go to EMIT.
  - EVAL therefore lasts ISECT_LAT+1 cycles.
- EMIT:
  - pix_valid=1. pix_x, pix_y, pix_hit and pix_last stay stable until the handshake completes.
  - pix_last = (x==H_RES-1)&&(y==V_RES-1).
  - On pix_ready&pix_valid:
    - Last pixel: go to DONE.
    - Else if x==H_RES-1: x←0, y←y+1, go to FETCH.
    - Else: x←x+1, go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- start in any non-IDLE state is ignored; rad_in is not re-sampled.
- Throughput with no backpressure and ISECT_LAT=0 is 3 cycles per pixel (FETCH, EVAL, EMIT). Frame length = H_RES·V_RES·(3+ISECT_LAT) cycles plus 1 DONE cycle.
- dir_valid deasserted in FETCH: stall indefinitely, with no change to outputs.
- pix_ready low in EMIT: stall indefinitely, with record outputs held.
- isect_hit is sampled only on the final EVAL cycle; at any other time it is don't-care.

Decomposition:
- Package ray_pkg:
  - DBL_W=64, VEC_W=192.
  - State enum {IDLE, FETCH, EVAL, EMIT, DONE}.
  - Direction field slice constants (X_HI/LO, Y_HI/LO, Z_HI/LO).
- Sub-module pixel_counter:
  - Parameterised by H_RES and V_RES.
  - Inputs clr and inc; outputs x, y, last.
  - Raster wrap logic is isolated there.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-frame (state EVAL) -> next cycle IDLE, all outputs 0, no done pulse; new start begins at x=y=0.
- Single frame, H_RES=4, V_RES=2, ISECT_LAT=0:
  - Stimulus: dir_valid and pix_ready tied high; stub intersect returns hit=dir_in[0]; dir x-field carries pixel index; rad_in=$realtobits(0.5).
  - Required: 8 records in raster order (0,0)…(3,1); hit matches the stub; pix_last only on (3,1); done 1 cycle after the last handshake; total 25 cycles from start accept.
  - Required: isect_rad=64'h3FE0000000000000 for the whole frame.
- ISECT_LAT=3:
  - Stimulus: dir_in={$realtobits(-0.0696257353), $realtobits(0.57209301), $realtobits(-1.0)}.
  - Required: EVAL lasts 4 cycles; stub hit toggles every cycle, and the captured value equals the stub's value on cycle 4 only; isect_dir stable throughout EVAL.
- Backpressure: pix_ready low for 5 cycles in EMIT and dir_valid low for 4 cycles in FETCH -> outputs frozen, no pixel skipped or duplicated, dir_ready high only while in FETCH.
- start pulsed during busy with rad_in=$realtobits(2.0) -> ignored; isect_rad keeps 0.5 until DONE; next start in IDLE latches 2.0.
- Row wrap: after accepting (H_RES-1, 0) -> next record is (0, 1); pix_last=0 on it.
